// File: rtl/powlib_bus_fifo.sv
// rtl/powlib_bus_fifo.sv - first-word-fall-through FIFO carrying paired address/data bus beats
// Programmable nearly-full flag lets upstream stages with in-flight beats throttle early.
module powlib_bus_fifo #(
  parameter string ID   = "BUSFIFO",
  parameter int    EDBG = 0,
  parameter int    D    = 8,
  parameter int    NFS  = 0,
  parameter int    B_AW = 32,
  parameter int    B_DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [B_AW-1:0] wraddr,
  input  logic [B_DW-1:0] wrdata,
  input  logic            wrvld,
  output logic            wrrdy,
  output logic            wrnf,
  output logic [B_AW-1:0] rdaddr,
  output logic [B_DW-1:0] rddata,
  output logic            rdvld,
  input  logic            rdrdy
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  localparam int EW = B_AW + B_DW;
  localparam logic [CW-1:0] DEPTH = CW'(D);

  logic [EW-1:0] mem [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free_slots;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  // Handshake flags come only from registered state, never from the opposite side's inputs.
  assign wrrdy      = (count != DEPTH);
  assign rdvld      = (count != '0);
  assign free_slots = DEPTH - count;
  assign wrnf       = (32'(free_slots) <= 32'(NFS));

  assign push = wrvld && wrrdy;
  assign pop  = rdvld && rdrdy;

  assign head   = mem[rd_ptr];
  assign rdaddr = head[EW-1:B_DW];
  assign rddata = head[B_DW-1:0];

  // Storage is intentionally left unreset; reset only empties the queue.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {wraddr, wrdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (EDBG != 0 && !rst) begin
      if (push) begin
        $display("%s push addr=%h data=%h", ID, wraddr, wrdata);
      end
      if (pop) begin
        $display("%s pop  addr=%h data=%h", ID, rdaddr, rddata);
      end
    end
  end
`endif

endmodule

// File: tb/tb_powlib_bus_fifo.sv
// tb/tb_powlib_bus_fifo.sv - self-checking bench for powlib_bus_fifo against a queue model
module tb_powlib_bus_fifo;
  localparam int D    = 8;
  localparam int NFS  = 3;
  localparam int B_AW = 32;
  localparam int B_DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [B_AW-1:0] wraddr;
  logic [B_DW-1:0] wrdata;
  logic            wrvld;
  logic            wrrdy;
  logic            wrnf;
  logic [B_AW-1:0] rdaddr;
  logic [B_DW-1:0] rddata;
  logic            rdvld;
  logic            rdrdy;

  int checks   = 0;
  int failures = 0;

  logic [B_AW+B_DW-1:0] model_q [$];

  powlib_bus_fifo #(
    .ID("BUSFIFO"), .EDBG(0), .D(D), .NFS(NFS), .B_AW(B_AW), .B_DW(B_DW)
  ) dut (
    .clk(clk), .rst(rst),
    .wraddr(wraddr), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy), .wrnf(wrnf),
    .rdaddr(rdaddr), .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // Reference: a queue of beats; push if room, pop if non-empty, reset empties it.
  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (rst) begin
      model_q.delete();
    end else begin
      do_push = wrvld && (model_q.size() < D);
      do_pop  = rdrdy && (model_q.size() > 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({wraddr, wrdata});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_rdvld", 64'(rdvld), 64'(model_q.size() != 0));
      chk("m_wrrdy", 64'(wrrdy), 64'(model_q.size() != D));
      chk("m_wrnf",  64'(wrnf),  64'((D - model_q.size()) <= NFS));
      if (model_q.size() != 0) begin
        chk("m_head", {rdaddr, rddata}, model_q[0]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drain();
    wrvld = 1'b0;
    rdrdy = 1'b1;
    for (int i = 0; i < 2 * D && rdvld; i++) step();
    rdrdy = 1'b0;
    chk("drain_empty", 64'(rdvld), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wrvld = 1'b0; rdrdy = 1'b0; wraddr = '0; wrdata = '0;
    step(); step();
    chk("rst_rdvld", 64'(rdvld), 64'(0));
    chk("rst_wrrdy", 64'(wrrdy), 64'(1));
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_rdvld", 64'(rdvld), 64'(0));
      chk("idle_wrrdy", 64'(wrrdy), 64'(1));
      chk("idle_wrnf",  64'(wrnf),  64'(0));
    end

    // Single beat, one-cycle latency
    wraddr = 32'h10; wrdata = 32'hA5A5A5A5; wrvld = 1'b1;
    step();
    wrvld = 1'b0;
    chk("single_rdvld", 64'(rdvld), 64'(1));
    chk("single_addr",  64'(rdaddr), 64'h10);
    chk("single_data",  64'(rddata), 64'hA5A5A5A5);
    rdrdy = 1'b1;
    step();
    rdrdy = 1'b0;
    chk("single_pop", 64'(rdvld), 64'(0));

    // Fill past full, then drain in order
    for (int i = 0; i < 9; i++) begin
      wraddr = 32'(i); wrdata = 32'(i * 3); wrvld = 1'b1;
      step();
      if (i == 3) chk("fill_wrnf_4", 64'(wrnf), 64'(0));
      if (i == 4) chk("fill_wrnf_5", 64'(wrnf), 64'(1));
      if (i == 6) chk("fill_wrrdy_7", 64'(wrrdy), 64'(1));
      if (i >= 7) chk("fill_full", 64'(wrrdy), 64'(0));
    end
    wrvld = 1'b0;
    rdrdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("fill_drain_addr", 64'(rdaddr), 64'(i));
      chk("fill_drain_data", 64'(rddata), 64'(i * 3));
      step();
    end
    rdrdy = 1'b0;
    chk("fill_drain_empty", 64'(rdvld), 64'(0));

    // Steady-state push/pop at 4 entries across pointer wrap
    for (int i = 0; i < 4; i++) begin
      wraddr = 32'h100 + 32'(i); wrdata = ~(32'h100 + 32'(i)); wrvld = 1'b1;
      step();
    end
    rdrdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wraddr = 32'h104 + 32'(k); wrdata = ~(32'h104 + 32'(k));
      chk("stream_head", 64'(rdaddr), 64'(32'h100 + 32'(k)));
      chk("stream_wrnf", 64'(wrnf), 64'(0));
      step();
    end
    drain();

    // Full with simultaneous write and read: only the pop happens
    for (int i = 0; i < 8; i++) begin
      wraddr = 32'h200 + 32'(i); wrdata = 32'(i); wrvld = 1'b1;
      step();
    end
    chk("full_wrrdy", 64'(wrrdy), 64'(0));
    wraddr = 32'hDEAD; rdrdy = 1'b1;
    step();
    wrvld = 1'b0; rdrdy = 1'b0;
    chk("full_pop_wrrdy", 64'(wrrdy), 64'(1));
    chk("full_pop_head",  64'(rdaddr), 64'h201);
    chk("full_pop_wrnf",  64'(wrnf), 64'(1));
    drain();

    // Reset with 5 entries stored
    for (int i = 0; i < 5; i++) begin
      wraddr = 32'h300 + 32'(i); wrdata = 32'(i); wrvld = 1'b1;
      step();
    end
    wrvld = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_rdvld", 64'(rdvld), 64'(0));
    chk("midrst_wrrdy", 64'(wrrdy), 64'(1));
    chk("midrst_wrnf",  64'(wrnf),  64'(0));
    wraddr = 32'h44; wrdata = 32'h4444; wrvld = 1'b1;
    step();
    wrvld = 1'b0;
    chk("midrst_first", 64'(rdaddr), 64'h44);
    drain();

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      wraddr = $urandom; wrdata = $urandom;
      wrvld  = ($urandom_range(0, 99) < 60);
      rdrdy  = ($urandom_range(0, 99) < ((k / 500) % 2 == 0 ? 40 : 75));
      rst    = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
